// File: rtl/framebuffer_arbiter.sv
// ---------------------------------------------------------------------------
// framebuffer_arbiter
//   Shares one single-port 16-bit framebuffer RAM between the pixel fetch
//   path (word reads, latency critical) and the UART command path (byte
//   writes). Reads normally win. A pending write that keeps losing is forced
//   through after WR_MAX_WAIT lost cycles. A one-entry posted-write holding
//   register decouples the UART writer from RAM contention.
//
// Ports
//   clk_in, reset        : clock, synchronous active-high reset
//   rd_req/rd_addr       : word read request, held until rd_ack
//   rd_ack               : read granted this cycle (combinational)
//   rd_data/rd_valid     : read word, rd_valid pulses 2 cycles after rd_ack
//   wr_req/wr_addr/wr_data : one-cycle byte write strobe, byte address, byte
//   wr_busy              : holding register occupied (registered)
//   wr_overflow          : sticky, a write strobe arrived while busy
//   wr_count             : writes committed to RAM, wraps at 256
//   ram_*                : RAM port; ram_data_in valid the cycle after address
// ---------------------------------------------------------------------------
module framebuffer_arbiter #(
    parameter int unsigned ADDR_WIDTH        = 11,
    parameter int unsigned WR_MAX_WAIT       = 8,
    parameter int unsigned WR_MAX_WAIT_WIDTH = 4
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ack,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH:0]   wr_addr,
    input  logic [7:0]            wr_data,
    output logic                  wr_busy,
    output logic                  wr_overflow,
    output logic [7:0]            wr_count,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [15:0]           ram_data_out,
    output logic [1:0]            ram_byte_we,
    output logic                  ram_clk_enable,
    input  logic [15:0]           ram_data_in
);

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } grant_t;

    localparam logic [WR_MAX_WAIT_WIDTH-1:0] STARVE_MAX = WR_MAX_WAIT_WIDTH'(WR_MAX_WAIT);

    // Holding register and status
    logic                          r_wr_busy;
    logic [ADDR_WIDTH:0]           r_wr_addr;
    logic [7:0]                    r_wr_data;
    logic                          r_wr_overflow;
    logic [7:0]                    r_wr_count;
    logic [WR_MAX_WAIT_WIDTH-1:0]  r_starve_cnt;

    // Read return pipeline: r_rd_pend marks that the RAM is presenting data
    // for a read granted in the previous cycle.
    logic                          r_rd_pend;
    logic                          r_rd_valid;
    logic [15:0]                   r_rd_data;

    grant_t                        w_grant;
    logic                          w_force_wr;

    // Arbitration. Grants are suppressed while reset is high so that nothing
    // reaches the RAM and no read enters the return pipeline.
    always_comb begin
        w_force_wr = r_wr_busy && (r_starve_cnt == STARVE_MAX);
        w_grant    = GNT_IDLE;
        if (!reset) begin
            if (r_wr_busy && (!rd_req || w_force_wr)) begin
                w_grant = GNT_WR;
            end else if (rd_req) begin
                w_grant = GNT_RD;
            end
        end
    end

    // RAM port and read acknowledge
    always_comb begin
        rd_ack         = 1'b0;
        ram_address    = '0;
        ram_data_out   = '0;
        ram_byte_we    = '0;
        ram_clk_enable = 1'b0;
        case (w_grant)
            GNT_RD: begin
                rd_ack         = 1'b1;
                ram_address    = rd_addr;
                ram_clk_enable = 1'b1;
            end
            GNT_WR: begin
                ram_address    = r_wr_addr[ADDR_WIDTH:1];
                ram_data_out   = {r_wr_data, r_wr_data};
                // Even byte address is the high byte (MSB-first pixel stream)
                ram_byte_we    = r_wr_addr[0] ? 2'b01 : 2'b10;
                ram_clk_enable = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_wr_busy     <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_wr_overflow <= 1'b0;
            r_wr_count    <= '0;
            r_starve_cnt  <= '0;
            r_rd_pend     <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
        end else begin
            r_rd_pend  <= (w_grant == GNT_RD);
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= ram_data_in;
            end

            // A strobe while busy (including the grant cycle) is dropped
            if (wr_req) begin
                if (r_wr_busy) begin
                    r_wr_overflow <= 1'b1;
                end else begin
                    r_wr_busy <= 1'b1;
                    r_wr_addr <= wr_addr;
                    r_wr_data <= wr_data;
                end
            end

            if (w_grant == GNT_WR) begin
                r_wr_busy    <= 1'b0;
                r_wr_count   <= r_wr_count + 8'd1;
                r_starve_cnt <= '0;
            end else if (r_wr_busy && (w_grant == GNT_RD) && (r_starve_cnt != STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + WR_MAX_WAIT_WIDTH'(1);
            end
        end
    end

    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign wr_busy     = r_wr_busy;
    assign wr_overflow = r_wr_overflow;
    assign wr_count    = r_wr_count;

endmodule
